// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions. Holds the 16550 interrupt identity
//                codes and the IER bit indices used by the interrupt arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // IIR[3:0] interrupt identity codes, 16550 register map
  typedef enum logic [3:0] {
    INT_ID_RLS  = 4'b0110,
    INT_ID_RDA  = 4'b0100,
    INT_ID_TMO  = 4'b1100,
    INT_ID_THRE = 4'b0010,
    INT_ID_MSR  = 4'b0000,
    INT_ID_NONE = 4'b0001
  } int_id_e;

  // IER bit positions
  localparam int c_IER_RDA  = 0;  // RX data available and character timeout
  localparam int c_IER_THRE = 1;  // transmit holding register empty
  localparam int c_IER_RLS  = 2;  // receiver line status
  localparam int c_IER_MSR  = 3;  // modem status

endpackage

`default_nettype wire

// File: rtl/uart_int_latch.sv
// ============================================================================
//  Module      : uart_int_latch
//  Description : Sticky pending bit for one interrupt source. A set in the
//                same cycle as a clear wins, so no event is ever lost.
//                The next-state value is exported because the arbiter
//                registers IIR from next-state pending, giving one-cycle
//                latency from source event to irq.
//  Ports       : clk, rst  - clock, synchronous active-high reset
//                set       - set request (priority over clr)
//                clr       - clear request
//                q_nxt     - value the bit takes at the next clock edge
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_int_latch (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic q_nxt
);

  logic r_pend;

  always_comb begin
    q_nxt = set | (r_pend & ~clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= 1'b0;
    end else begin
      r_pend <= q_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_int_ctrl.sv
// ============================================================================
//  Module      : uart_int_ctrl
//  Description : 16550-style interrupt arbiter. Latches the sticky sources
//                (line status, THR empty, modem status), prioritises all
//                enabled sources onto irq and builds the IIR read value.
//                Implements the clear-on-read side effects of IIR/LSR/MSR.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                int_rx_timeout    - RX character timeout (level)
//                rx_trig           - RX FIFO at/above trigger (level)
//                lsr_err           - line status error (pulse)
//                thr_empty         - THR/TX FIFO empty (level)
//                msr_delta         - modem status delta (pulse)
//                rd_iir/rd_lsr/rd_msr - register read strobes
//                wr_thr            - THR write strobe
//                cfg_ier[3:0]      - interrupt enables
//                cfg_fifo_enable   - FCR[0]
//                irq               - registered interrupt request
//                iir[7:0]          - registered IIR read value
//  Config      : UART_INT_MODEM_EN - implements the modem status source;
//                when undefined the MSR source is absent entirely.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_int_ctrl
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       int_rx_timeout,
  input  logic       rx_trig,
  input  logic       lsr_err,
  input  logic       thr_empty,
  input  logic       msr_delta,
  input  logic       rd_iir,
  input  logic       rd_lsr,
  input  logic       rd_msr,
  input  logic       wr_thr,
  input  logic [3:0] cfg_ier,
  input  logic       cfg_fifo_enable,
  output logic       irq,
  output logic [7:0] iir
);

  logic       r_thr_empty_d;  // previous thr_empty, for rising-edge detect
  logic       r_ier_thre_d;   // previous IER THRE enable, for re-arm detect
  logic       r_irq;
  logic [7:0] r_iir;

  logic       w_lsr_nxt;
  logic       w_thre_nxt;
  logic       w_msr_nxt;
  logic       w_thre_set;
  logic       w_thre_clr;
  int_id_e    w_id;

  // --------------------------------------------------------------------------
  // Pending latches
  // --------------------------------------------------------------------------
  uart_int_latch u_lsr_pend (
    .clk   (clk),
    .rst   (rst),
    .set   (lsr_err),
    .clr   (rd_lsr),
    .q_nxt (w_lsr_nxt)
  );

  // THRE arms on a new empty condition, or when software enables THRE while
  // the transmitter is already empty. Reading IIR clears it only when THRE
  // is the identity the host actually saw.
  assign w_thre_set = (thr_empty & ~r_thr_empty_d) |
                      (cfg_ier[c_IER_THRE] & ~r_ier_thre_d & thr_empty);
  assign w_thre_clr = wr_thr | (rd_iir & (r_iir[3:0] == INT_ID_THRE));

  uart_int_latch u_thre_pend (
    .clk   (clk),
    .rst   (rst),
    .set   (w_thre_set),
    .clr   (w_thre_clr),
    .q_nxt (w_thre_nxt)
  );

`ifdef UART_INT_MODEM_EN
  uart_int_latch u_msr_pend (
    .clk   (clk),
    .rst   (rst),
    .set   (msr_delta),
    .clr   (rd_msr),
    .q_nxt (w_msr_nxt)
  );
`else
  // Modem source absent: its inputs are intentionally ignored.
  logic w_unused_msr;
  assign w_unused_msr = &{1'b0, msr_delta, rd_msr, cfg_ier[c_IER_MSR]};
  assign w_msr_nxt    = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Priority encoder over next-state pending plus current levels
  // --------------------------------------------------------------------------
  always_comb begin
    w_id = INT_ID_NONE;
    if (w_lsr_nxt && cfg_ier[c_IER_RLS]) begin
      w_id = INT_ID_RLS;
    end else if (rx_trig && cfg_ier[c_IER_RDA]) begin
      w_id = INT_ID_RDA;
    end else if (int_rx_timeout && cfg_ier[c_IER_RDA] && cfg_fifo_enable) begin
      w_id = INT_ID_TMO;
    end else if (w_thre_nxt && cfg_ier[c_IER_THRE]) begin
      w_id = INT_ID_THRE;
`ifdef UART_INT_MODEM_EN
    end else if (w_msr_nxt && cfg_ier[c_IER_MSR]) begin
      w_id = INT_ID_MSR;
`endif
    end else begin
      w_id = INT_ID_NONE;
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs and edge-detect history
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq         <= 1'b0;
      r_iir         <= 8'h01;
      r_thr_empty_d <= 1'b1;
      r_ier_thre_d  <= 1'b0;
    end else begin
      r_irq         <= ~w_id[0];
      r_iir         <= {{2{cfg_fifo_enable}}, 2'b00, w_id};
      r_thr_empty_d <= thr_empty;
      r_ier_thre_d  <= cfg_ier[c_IER_THRE];
    end
  end

  assign irq = r_irq;
  assign iir = r_iir;

endmodule

`default_nettype wire
